// File: rtl/dsp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_rr_arbiter
// Purpose  : Round-robin arbiter sharing one registered DSP multiply block
//            between NUM_REQ requesters. It accepts one operation per cycle,
//            registers the operands/mode towards the DSP, and carries each
//            operation's requester tag through the DSP latency so the result
//            can be returned to its owner.
// Ports    : clk, rst_n              - clock (also the DSP clock), sync active-low reset
//            req_valid / req_ready   - per-requester handshake (ready is one-hot)
//            req_a / req_b / req_m   - packed per-requester operands and mode bit
//            dsp_a / dsp_b / dsp_m   - registered operands and mode to the DSP
//            dsp_out                 - DSP result
//            resp_valid / resp_id    - result present / owning requester
//            resp_data               - pass-through of dsp_out
//            busy                    - at least one operation in flight
// Revision : 1.0 - initial release
// ============================================================================
module dsp_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int DSP_LATENCY = 2,
    parameter int ID_WIDTH    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*(DATA_WIDTH/2)-1:0]   req_a,
    input  logic [NUM_REQ*(DATA_WIDTH/2)-1:0]   req_b,
    input  logic [NUM_REQ-1:0]                  req_m,
    output logic [DATA_WIDTH/2-1:0]             dsp_a,
    output logic [DATA_WIDTH/2-1:0]             dsp_b,
    output logic                                dsp_m,
    input  logic [DATA_WIDTH-1:0]               dsp_out,
    output logic                                resp_valid,
    output logic [ID_WIDTH-1:0]                 resp_id,
    output logic [DATA_WIDTH-1:0]               resp_data,
    output logic                                busy
);

    localparam int OP_W  = DATA_WIDTH / 2;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra stage on top of the DSP latency covers the operand register
    // in this block that sits in front of the DSP input register.
    localparam int DEPTH = DSP_LATENCY + 1;

    // (base + off) mod NUM_REQ; base < NUM_REQ and off < NUM_REQ, so a single
    // conditional subtraction is enough.
    function automatic logic [PTR_W-1:0] f_wrap_add(input logic [PTR_W-1:0] base,
                                                    input int off);
        logic [PTR_W:0] s;
        s = {1'b0, base} + {1'b0, PTR_W'(off)};
        if (s >= (PTR_W+1)'(NUM_REQ)) begin
            s = s - (PTR_W+1)'(NUM_REQ);
        end
        return s[PTR_W-1:0];
    endfunction

    logic [PTR_W-1:0]               r_ptr;
    logic [OP_W-1:0]                r_dsp_a;
    logic [OP_W-1:0]                r_dsp_b;
    logic                           r_dsp_m;
    logic [DEPTH-1:0]               r_tag_v;
    logic [DEPTH-1:0][ID_WIDTH-1:0] r_tag_id;

    logic                           w_found;
    logic [PTR_W-1:0]               w_gnt_idx;
    logic [NUM_REQ-1:0]             w_gnt_onehot;
    logic                           w_xfer;
    logic [OP_W-1:0]                w_sel_a;
    logic [OP_W-1:0]                w_sel_b;
    logic                           w_sel_m;

    // ------------------------------------------------------------------
    // Grant search: first valid requester starting at the pointer.
    // ------------------------------------------------------------------
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[f_wrap_add(r_ptr, k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = f_wrap_add(r_ptr, k);
            end
        end
        w_gnt_onehot = '0;
        if (w_found) begin
            w_gnt_onehot[w_gnt_idx] = 1'b1;
        end
    end

    // Ready is held low during reset so no transfer is ever seen while the
    // state is being cleared.
    always_comb begin
        req_ready = rst_n ? w_gnt_onehot : '0;
    end

    assign w_xfer = |(req_valid & req_ready);

    // AND-OR operand mux keyed by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_m = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_a = req_a[i*OP_W +: OP_W];
                w_sel_b = req_b[i*OP_W +: OP_W];
                w_sel_m = req_m[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer and DSP operand registers: update only on a transfer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_dsp_a <= '0;
            r_dsp_b <= '0;
            r_dsp_m <= 1'b0;
        end else if (w_xfer) begin
            r_ptr   <= f_wrap_add(w_gnt_idx, 1);
            r_dsp_a <= w_sel_a;
            r_dsp_b <= w_sel_b;
            r_dsp_m <= w_sel_m;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: shifts every cycle; idle cycles insert a bubble. Bubble
    // ids are zeroed so resp_id reads 0 whenever no result is present.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v     <= {r_tag_v[DEPTH-2:0], w_xfer};
            r_tag_id[0] <= w_xfer ? ID_WIDTH'(w_gnt_idx) : '0;
            for (int s = 1; s < DEPTH; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    assign dsp_a      = r_dsp_a;
    assign dsp_b      = r_dsp_b;
    assign dsp_m      = r_dsp_m;
    assign resp_valid = r_tag_v[DEPTH-1];
    assign resp_id    = r_tag_id[DEPTH-1];
    assign resp_data  = dsp_out;
    assign busy       = |r_tag_v;

endmodule
`default_nettype wire

// File: tb/tb_dsp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_rr_arbiter
// Purpose  : Self-checking bench for dsp_rr_arbiter with a two-stage DSP
//            stand-in producing dsp_out = {a,b}. A per-cycle vector table is
//            applied and compared, followed by a hand-written reset-in-flight
//            sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_m;
    logic [1:0] dsp_a;
    logic [1:0] dsp_b;
    logic       dsp_m;
    logic [3:0] dsp_out;
    logic       resp_valid;
    logic [1:0] resp_id;
    logic [3:0] resp_data;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_rr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (4),
        .DSP_LATENCY(2),
        .ID_WIDTH   (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_m     (dsp_m),
        .dsp_out   (dsp_out),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .busy      (busy)
    );

    // DSP stand-in: input register then output register.
    logic [3:0] r_dsp_in;
    logic [3:0] r_dsp_q;
    always_ff @(posedge clk) begin
        r_dsp_in <= {dsp_a, dsp_b};
        r_dsp_q  <= r_dsp_in;
    end
    assign dsp_out = r_dsp_q;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [1:0] da;
        logic [1:0] db;
        logic       dm;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rdata;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] r, logic [1:0] a, logic [1:0] b,
                                logic m, logic rv, logic [1:0] id, logic [3:0] d, logic bz);
        vec_t x;
        x.valid = v; x.ready = r; x.da = a; x.db = b; x.dm = m;
        x.rv = rv; x.rid = id; x.rdata = d; x.busy = bz;
        return x;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle: drive inputs just after the edge, then return at the
    // falling edge where outputs are sampled.
    task automatic step(input logic rst_v, input logic [3:0] v);
        @(posedge clk);
        #1;
        rst_n     = rst_v;
        req_valid = v;
        @(negedge clk);
    endtask

    initial begin
        // Fixed operands: a = {0,2,3,1}, b = {3,3,1,2}, m = {1,0,1,0} for req 3..0.
        // Results {a,b}: r0=6, r1=D, r2=B, r3=3.
        req_a     = 8'b00_10_11_01;
        req_b     = 8'b11_11_01_10;
        req_m     = 4'b1010;
        rst_n     = 1'b0;
        req_valid = 4'hF;

        // Reset state, with all requests valid to show ready is forced low.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", -1, 8'(req_ready), 8'h0);
        chk("rst_dsp_a", -1, 8'(dsp_a), 8'h0);
        chk("rst_dsp_b", -1, 8'(dsp_b), 8'h0);
        chk("rst_dsp_m", -1, 8'(dsp_m), 8'h0);
        chk("rst_resp_valid", -1, 8'(resp_valid), 8'h0);
        chk("rst_resp_id", -1, 8'(resp_id), 8'h0);
        chk("rst_busy", -1, 8'(busy), 8'h0);

        //                valid  ready  da    db    dm  rv  rid   data  busy
        // all four valid, grants 0,1,2,3,0
        tbl.push_back(mk(4'hF, 4'h1, 2'd0, 2'd0, 0, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(4'hF, 4'h2, 2'd1, 2'd2, 0, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'hF, 4'h4, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'hF, 4'h8, 2'd2, 2'd3, 0, 1, 2'd0, 4'h6, 1));
        tbl.push_back(mk(4'hF, 4'h1, 2'd0, 2'd3, 1, 1, 2'd1, 4'hD, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd1, 2'd2, 0, 1, 2'd2, 4'hB, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd1, 2'd2, 0, 1, 2'd3, 4'h3, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd1, 2'd2, 0, 1, 2'd0, 4'h6, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd1, 2'd2, 0, 0, 2'd0, 4'h0, 0));
        // single request from requester 1 (ptr=1)
        tbl.push_back(mk(4'h2, 4'h2, 2'd1, 2'd2, 0, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 1, 2'd1, 4'hD, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 0));
        // wrap-around from ptr=2 with 0 and 1 valid
        tbl.push_back(mk(4'h3, 4'h1, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(4'h2, 4'h2, 2'd1, 2'd2, 0, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 1, 2'd0, 4'h6, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd3, 2'd1, 1, 1, 2'd1, 4'hD, 1));
        // lone requester 3 for three cycles
        tbl.push_back(mk(4'h8, 4'h8, 2'd3, 2'd1, 1, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(4'h8, 4'h8, 2'd0, 2'd3, 1, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'h8, 4'h8, 2'd0, 2'd3, 1, 0, 2'd0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd0, 2'd3, 1, 1, 2'd3, 4'h3, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd0, 2'd3, 1, 1, 2'd3, 4'h3, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'd0, 2'd3, 1, 1, 2'd3, 4'h3, 1));
        // idle for ten cycles
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(4'h0, 4'h0, 2'd0, 2'd3, 1, 0, 2'd0, 4'h0, 0));
        end

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].valid);
            chk("ready", i, 8'(req_ready), 8'(tbl[i].ready));
            chk("dsp_a", i, 8'(dsp_a), 8'(tbl[i].da));
            chk("dsp_b", i, 8'(dsp_b), 8'(tbl[i].db));
            chk("dsp_m", i, 8'(dsp_m), 8'(tbl[i].dm));
            chk("resp_valid", i, 8'(resp_valid), 8'(tbl[i].rv));
            chk("busy", i, 8'(busy), 8'(tbl[i].busy));
            if (tbl[i].rv) begin
                chk("resp_id", i, 8'(resp_id), 8'(tbl[i].rid));
                chk("resp_data", i, 8'(resp_data), 8'(tbl[i].rdata));
            end
        end

        // Reset in flight: two grants (0 then 1), then one reset cycle.
        step(1'b1, 4'h3);
        chk("mid_grant0", 100, 8'(req_ready), 8'h1);
        step(1'b1, 4'h2);
        chk("mid_grant1", 101, 8'(req_ready), 8'h2);
        step(1'b0, 4'h4);
        chk("mid_rst_ready", 102, 8'(req_ready), 8'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'h0);
            chk("mid_resp_valid", 103 + i, 8'(resp_valid), 8'h0);
            if (i == 0) begin
                chk("mid_dsp_a", 103, 8'(dsp_a), 8'h0);
                chk("mid_dsp_b", 103, 8'(dsp_b), 8'h0);
                chk("mid_dsp_m", 103, 8'(dsp_m), 8'h0);
                chk("mid_busy", 103, 8'(busy), 8'h0);
            end
        end
        // Pointer must be back at 0: with 1 and 3 valid, requester 1 wins.
        step(1'b1, 4'hA);
        chk("mid_ptr_zero", 108, 8'(req_ready), 8'h2);
        step(1'b1, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
